// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - F1 start-light reaction timer with jump-start and timeout flags
module f1_reaction_timer #(
    parameter int D_WIDTH = 8,
    parameter int T_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [D_WIDTH-1:0] lights,
    input  logic               trigger,
    output logic [T_WIDTH-1:0] react_time,
    output logic               valid,
    output logic               jump_start,
    output logic               timeout,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FOUL} state_t;

    localparam logic [T_WIDTH-1:0] CNT_MAX = '1;

    state_t             state, state_next;
    logic [T_WIDTH-1:0] counter;
    logic               trigger_q;
    logic [D_WIDTH-1:0] lights_q;

    logic trig_rise, new_round, all_on, all_off;
    logic cnt_clear, cnt_inc, capture, capture_sat, set_jump, clear_flags;

    assign trig_rise = trigger & ~trigger_q;
    assign all_on    = (lights == {D_WIDTH{1'b1}});
    assign all_off   = (lights == '0);
    assign new_round = !all_off && (lights_q == '0);
    assign busy      = (state == ARMED) || (state == TIMING);

    always_comb begin
        state_next  = state;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        capture     = 1'b0;
        capture_sat = 1'b0;
        set_jump    = 1'b0;
        clear_flags = 1'b0;
        case (state)
            IDLE: begin
                if (all_on) state_next = ARMED;
            end
            ARMED: begin
                // A press while the lights are still lit beats a same-cycle lights-out.
                if (trig_rise) begin
                    state_next = FOUL;
                    set_jump   = 1'b1;
                end else if (all_off) begin
                    state_next = TIMING;
                    cnt_clear  = 1'b1;
                end
            end
            TIMING: begin
                if (trig_rise) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end else if (tick) begin
                    if (counter == CNT_MAX) begin
                        state_next  = DONE;
                        capture_sat = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE, FOUL: begin
                if (new_round) begin
                    state_next  = IDLE;
                    clear_flags = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            react_time <= '0;
            trigger_q  <= 1'b0;
            lights_q   <= '0;
            valid      <= 1'b0;
            jump_start <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state     <= state_next;
            trigger_q <= trigger;
            lights_q  <= lights;
            if (cnt_clear)
                counter <= '0;
            else if (cnt_inc)
                counter <= counter + T_WIDTH'(1);
            if (capture) begin
                react_time <= counter;
                valid      <= 1'b1;
            end
            if (capture_sat) begin
                react_time <= CNT_MAX;
                valid      <= 1'b1;
                timeout    <= 1'b1;
            end
            if (set_jump)
                jump_start <= 1'b1;
            if (clear_flags) begin
                valid      <= 1'b0;
                jump_start <= 1'b0;
                timeout    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb/tb_f1_reaction_timer.sv - scoreboard bench for f1_reaction_timer
module tb_f1_reaction_timer;

    typedef struct packed {
        logic [15:0] rt;
        logic        v;
        logic        js;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, tick, trigger;
    logic [7:0]  lights;
    logic [15:0] react_time;
    logic        valid, jump_start, timeout, busy;

    logic        tick_s, trigger_s;
    logic [7:0]  lights_s;
    logic [3:0]  react_time_s;
    logic        valid_s, jump_start_s, timeout_s, busy_s;

    exp_t q[$];
    exp_t q_s[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    f1_reaction_timer #(.D_WIDTH(8), .T_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights), .trigger(trigger),
        .react_time(react_time), .valid(valid), .jump_start(jump_start),
        .timeout(timeout), .busy(busy)
    );

    f1_reaction_timer #(.D_WIDTH(8), .T_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .tick(tick_s), .lights(lights_s), .trigger(trigger_s),
        .react_time(react_time_s), .valid(valid_s), .jump_start(jump_start_s),
        .timeout(timeout_s), .busy(busy_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ramp;
        lights = 8'h00;
        step;
        for (int i = 0; i < 8; i++) begin
            lights = {lights[6:0], 1'b1};
            step;
        end
    endtask

    task automatic lights_out;
        lights = 8'h00;
        step;
    endtask

    task automatic ticks(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step;
            tick = 1'b0;
            repeat (period - 1) step;
        end
    endtask

    // Main monitor: a result or foul is presented when valid or jump_start rises.
    initial begin
        logic v_prev, j_prev;
        exp_t e;
        v_prev = 1'b0;
        j_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((valid && !v_prev) || (jump_start && !j_prev)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: react_time=%0d valid=%0b jump_start=%0b", react_time, valid, jump_start);
                end else begin
                    e = q.pop_front();
                    check("react_time", react_time, e.rt);
                    check("valid", valid, e.v);
                    check("jump_start", jump_start, e.js);
                    check("timeout", timeout, e.to);
                end
            end
            v_prev = valid;
            j_prev = jump_start;
        end
    end

    initial begin
        logic v_prev;
        exp_t e;
        v_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_s && !v_prev) begin
                if (q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_small_output: react_time=%0d", react_time_s);
                end else begin
                    e = q_s.pop_front();
                    check("small_react_time", react_time_s, e.rt);
                    check("small_valid", valid_s, e.v);
                    check("small_jump_start", jump_start_s, e.js);
                    check("small_timeout", timeout_s, e.to);
                end
            end
            v_prev = valid_s;
        end
    end

    initial begin
        rst = 1'b0; tick = 1'b0; trigger = 1'b0; lights = 8'h00;
        tick_s = 1'b0; trigger_s = 1'b0; lights_s = 8'h00;
        #2;
        check("rst_react_time", react_time, 0);
        check("rst_valid", valid, 0);
        check("rst_jump_start", jump_start, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        step; step;
        rst = 1'b1;
        step;

        // Normal round: 25 ticks at 4 clk spacing
        q.push_back('{rt: 16'd25, v: 1'b1, js: 1'b0, to: 1'b0});
        ramp;
        check("armed_busy", busy, 1);
        lights_out;
        ticks(25, 4);
        check("timing_busy", busy, 1);
        check("no_early_valid", valid, 0);
        trigger = 1'b1;
        step;
        check("busy_falls", busy, 0);
        trigger = 1'b0;
        ramp;
        check("valid_cleared", valid, 0);
        check("rt_retained", react_time, 25);

        // Jump start from ARMED
        q.push_back('{rt: 16'd25, v: 1'b0, js: 1'b1, to: 1'b0});
        trigger = 1'b1;
        step;
        check("foul_busy", busy, 0);
        trigger = 1'b0;
        lights = 8'h00;
        step;
        check("foul_hold_js", jump_start, 1);
        lights = 8'h01;
        step;
        check("js_cleared", jump_start, 0);
        check("idle_busy", busy, 0);

        // Tick and trigger edge in the same cycle
        q.push_back('{rt: 16'd10, v: 1'b1, js: 1'b0, to: 1'b0});
        ramp;
        lights_out;
        ticks(10, 2);
        tick = 1'b1; trigger = 1'b1;
        step;
        tick = 1'b0; trigger = 1'b0;
        step;

        // Trigger held through lights-out, stray patterns during timing
        q.push_back('{rt: 16'd12, v: 1'b1, js: 1'b0, to: 1'b0});
        trigger = 1'b1;
        ramp;
        lights_out;
        lights = 8'h5A;
        ticks(5, 3);
        trigger = 1'b0;
        lights = 8'hFF;
        ticks(7, 3);
        check("held_busy", busy, 1);
        trigger = 1'b1;
        step;
        trigger = 1'b0;
        step;

        // Asynchronous reset during TIMING
        ramp;
        lights_out;
        ticks(3, 2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_react_time", react_time, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_jump_start", jump_start, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_busy", busy, 0);
        step;
        rst = 1'b1;
        step;
        q.push_back('{rt: 16'd7, v: 1'b1, js: 1'b0, to: 1'b0});
        ramp;
        lights_out;
        ticks(7, 2);
        trigger = 1'b1;
        step;
        trigger = 1'b0;
        step;

        // Saturation with a 4-bit counter
        q_s.push_back('{rt: 16'd15, v: 1'b1, js: 1'b0, to: 1'b1});
        lights_s = 8'hFF;
        step;
        lights_s = 8'h00;
        step;
        tick_s = 1'b1;
        repeat (15) step;
        check("small_no_early_valid", valid_s, 0);
        check("small_busy", busy_s, 1);
        step;
        tick_s = 1'b0;
        step;
        check("small_busy_after", busy_s, 0);

        repeat (3) step;
        check("queue_drained", q.size(), 0);
        check("small_queue_drained", q_s.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
